// File: rtl/axi_burst_responder.sv
// AXI4 slave with independent write and read burst engines over a byte-strobed
// word memory; INCR bursts of full-width beats only, anything else answers SLVERR.
module axi_burst_responder #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 128,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH-1:0]   hp_awaddr,
  input  logic [7:0]              hp_awlen,
  input  logic [2:0]              hp_awsize,
  input  logic [1:0]              hp_awburst,
  input  logic                    hp_awvalid,
  output logic                    hp_awready,
  input  logic [DATA_WIDTH-1:0]   hp_wdata,
  input  logic [DATA_WIDTH/8-1:0] hp_wstrb,
  input  logic                    hp_wlast,
  input  logic                    hp_wvalid,
  output logic                    hp_wready,
  output logic [1:0]              hp_bresp,
  output logic                    hp_bvalid,
  input  logic                    hp_bready,
  input  logic [ADDR_WIDTH-1:0]   hp_araddr,
  input  logic [7:0]              hp_arlen,
  input  logic [2:0]              hp_arsize,
  input  logic [1:0]              hp_arburst,
  input  logic                    hp_arvalid,
  output logic                    hp_arready,
  output logic [DATA_WIDTH-1:0]   hp_rdata,
  output logic [1:0]              hp_rresp,
  output logic                    hp_rlast,
  output logic                    hp_rvalid,
  input  logic                    hp_rready,
  output logic [1:0]              dbg_w_state,
  output logic                    dbg_r_state
);
  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int SIZE_LOG = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT      = ADDR_WIDTH'(MEM_WORDS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, BURST_INCR = 2'b01;

  // Every channel transfers on a rising edge where valid and ready are both 1;
  // a source holds its payload stable from raising valid until that edge.

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t              w_state, w_state_n;
  logic [ADDR_WIDTH-1:0] w_base, w_base_n, w_addr;
  logic [7:0]            w_len, w_len_n, w_beat, w_beat_n;
  logic                  w_err, w_err_n, w_fire, w_beat_err, mem_we;
  logic                  awready_n, wready_n, bvalid_n;
  logic [1:0]            bresp_n;

  assign w_addr     = w_base + (ADDR_WIDTH'(w_beat) << SIZE_LOG);
  assign w_fire     = hp_wvalid & hp_wready;
  assign w_beat_err = (w_addr >= LIMIT) | (hp_wlast != (w_beat == w_len));
  // Once a burst is flagged, no later beat of it touches memory.
  assign mem_we     = w_fire & ~w_err & ~w_beat_err;

  always_comb begin
    w_state_n = w_state;
    w_base_n  = w_base;
    w_len_n   = w_len;
    w_beat_n  = w_beat;
    w_err_n   = w_err;
    bvalid_n  = hp_bvalid;
    bresp_n   = hp_bresp;
    case (w_state)
      W_IDLE: if (hp_awvalid && hp_awready) begin
        w_base_n  = hp_awaddr & ALIGN_MASK;
        w_len_n   = hp_awlen;
        w_beat_n  = 8'd0;
        w_err_n   = (hp_awburst != BURST_INCR) || (hp_awsize != 3'(SIZE_LOG));
        w_state_n = W_DATA;
      end
      W_DATA: if (w_fire) begin
        w_err_n  = w_err | w_beat_err;
        w_beat_n = w_beat + 8'd1;
        if (w_beat == w_len) begin
          w_state_n = W_RESP;
          bvalid_n  = 1'b1;
          bresp_n   = w_err_n ? SLVERR : OKAY;
        end
      end
      W_RESP: if (hp_bready) begin
        w_state_n = W_IDLE;
        bvalid_n  = 1'b0;
        bresp_n   = OKAY;
      end
      default: w_state_n = W_IDLE;
    endcase
    awready_n = (w_state_n == W_IDLE);
    wready_n  = (w_state_n == W_DATA);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state    <= W_IDLE;
      w_base     <= '0;
      w_len      <= '0;
      w_beat     <= '0;
      w_err      <= 1'b0;
      hp_awready <= 1'b0;
      hp_wready  <= 1'b0;
      hp_bvalid  <= 1'b0;
      hp_bresp   <= OKAY;
    end else begin
      w_state    <= w_state_n;
      w_base     <= w_base_n;
      w_len      <= w_len_n;
      w_beat     <= w_beat_n;
      w_err      <= w_err_n;
      hp_awready <= awready_n;
      hp_wready  <= wready_n;
      hp_bvalid  <= bvalid_n;
      hp_bresp   <= bresp_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (hp_wstrb[b]) mem[w_addr[SIZE_LOG +: IDX_W]][b*8 +: 8] <= hp_wdata[b*8 +: 8];
      end
    end
  end

  r_state_t              r_state, r_state_n;
  logic [ADDR_WIDTH-1:0] r_base, r_base_n, ld_base, ld_addr;
  logic [7:0]            r_len, r_len_n, r_beat, r_beat_n, ld_len, ld_beat;
  logic                  r_berr, r_berr_n, ld_berr, ld_err, ld_go;
  logic                  arready_n, rvalid_n, rlast_n;
  logic [1:0]            rresp_n;
  logic [DATA_WIDTH-1:0] rdata_n;

  // The beat being loaded into the output register is either beat 0 of a new
  // request or the successor of the beat currently being handed over.
  assign ld_base = (r_state == R_IDLE) ? (hp_araddr & ALIGN_MASK) : r_base;
  assign ld_len  = (r_state == R_IDLE) ? hp_arlen : r_len;
  assign ld_beat = (r_state == R_IDLE) ? 8'd0 : r_beat + 8'd1;
  assign ld_berr = (r_state == R_IDLE)
                 ? ((hp_arburst != BURST_INCR) || (hp_arsize != 3'(SIZE_LOG))) : r_berr;
  assign ld_addr = ld_base + (ADDR_WIDTH'(ld_beat) << SIZE_LOG);
  assign ld_err  = ld_berr | (ld_addr >= LIMIT);
  assign ld_go   = (r_state == R_IDLE) ? (hp_arvalid & hp_arready)
                                       : (hp_rvalid & hp_rready & ~hp_rlast);

  always_comb begin
    r_state_n = r_state;
    r_base_n  = r_base;
    r_len_n   = r_len;
    r_beat_n  = r_beat;
    r_berr_n  = r_berr;
    rvalid_n  = hp_rvalid;
    rlast_n   = hp_rlast;
    rresp_n   = hp_rresp;
    rdata_n   = hp_rdata;
    if (ld_go) begin
      r_state_n = R_DATA;
      r_base_n  = ld_base;
      r_len_n   = ld_len;
      r_beat_n  = ld_beat;
      r_berr_n  = ld_berr;
      rvalid_n  = 1'b1;
      rlast_n   = (ld_beat == ld_len);
      rresp_n   = ld_err ? SLVERR : OKAY;
      rdata_n   = ld_err ? '0 : mem[ld_addr[SIZE_LOG +: IDX_W]];
    end else if (r_state == R_DATA && hp_rvalid && hp_rready) begin
      r_state_n = R_IDLE;
      rvalid_n  = 1'b0;
      rlast_n   = 1'b0;
      rresp_n   = OKAY;
      rdata_n   = '0;
    end
    arready_n = (r_state_n == R_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= R_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_berr     <= 1'b0;
      hp_arready <= 1'b0;
      hp_rvalid  <= 1'b0;
      hp_rlast   <= 1'b0;
      hp_rresp   <= OKAY;
      hp_rdata   <= '0;
    end else begin
      r_state    <= r_state_n;
      r_base     <= r_base_n;
      r_len      <= r_len_n;
      r_beat     <= r_beat_n;
      r_berr     <= r_berr_n;
      hp_arready <= arready_n;
      hp_rvalid  <= rvalid_n;
      hp_rlast   <= rlast_n;
      hp_rresp   <= rresp_n;
      hp_rdata   <= rdata_n;
    end
  end

  assign dbg_w_state = w_state;
  assign dbg_r_state = r_state;
endmodule
